// File: rtl/mcu_icache_refill_if.sv
// Miss-port and memory-bus signal bundle for the I-cache refill engine.
// master = refill engine, slave = cache plus memory side.
interface mcu_icache_refill_if #(
   parameter int LINE_BYTES = 32
);
   logic                    miss_req_valid;
   logic [31:0]             miss_req_addr;
   logic                    miss_req_ready;
   logic                    miss_resp_valid;
   logic [LINE_BYTES*8-1:0] miss_resp_data;
   logic                    miss_resp_err;
   logic                    mem_req_valid;
   logic [31:0]             mem_req_addr;
   logic                    mem_req_ready;
   logic                    mem_resp_valid;
   logic [31:0]             mem_resp_data;
   logic                    mem_resp_err;

   modport master (
      input  miss_req_valid, miss_req_addr, mem_req_ready,
             mem_resp_valid, mem_resp_data, mem_resp_err,
      output miss_req_ready, miss_resp_valid, miss_resp_data, miss_resp_err,
             mem_req_valid, mem_req_addr
   );

   modport slave (
      output miss_req_valid, miss_req_addr, mem_req_ready,
             mem_resp_valid, mem_resp_data, mem_resp_err,
      input  miss_req_ready, miss_resp_valid, miss_resp_data, miss_resp_err,
             mem_req_valid, mem_req_addr
   );
endinterface

// File: rtl/mcu_icache_refill.sv
// Single-line I-cache refill: BEATS word reads, one outstanding, assembled line returned as a
// one-cycle pulse 2*BEATS+1 cycles after acceptance on zero-wait memory; no backpressure on the response.
module mcu_icache_refill #(
   parameter int LINE_BYTES = 32,
   parameter int WORD_BYTES = 4
) (
   input  logic                clk,
   input  logic                rst,
   mcu_icache_refill_if.master bus
);
   localparam int WORD_W = WORD_BYTES * 8;
   localparam int BEATS  = LINE_BYTES / WORD_BYTES;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int OFF_W  = $clog2(LINE_BYTES);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t                  state, state_nxt;
   logic [BEAT_W-1:0]       beat;
   logic [31:0]             req_addr;
   logic [LINE_BYTES*8-1:0] line, line_merged, resp_line;
   logic                    err_flag;
   logic                    accept, beat_done, last_beat;
   logic                    unused_addr_bits;

   assign accept           = (state == IDLE) && bus.miss_req_valid;
   assign beat_done        = (state == WAIT) && bus.mem_resp_valid;
   assign last_beat        = (beat == LAST_BEAT);
   assign unused_addr_bits = ^bus.miss_req_addr[OFF_W-1:0];

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.miss_req_valid) state_nxt = REQ;
         REQ:     if (bus.mem_req_ready)  state_nxt = WAIT;
         WAIT:    if (bus.mem_resp_valid) state_nxt = last_beat ? DONE : REQ;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.miss_req_ready  = (state == IDLE);
      bus.mem_req_valid   = (state == REQ);
      bus.mem_req_addr    = req_addr;
      bus.miss_resp_valid = (state == DONE);
      bus.miss_resp_data  = resp_line;
      bus.miss_resp_err   = (state == DONE) && err_flag;
   end

   always_comb begin
      line_merged = line;
      line_merged[WORD_W*int'(beat) +: WORD_W] = bus.mem_resp_data;
   end

   // resp_line is separate from the assembly buffer so the last returned line stays visible
   // while the next refill overwrites the buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat      <= '0;
         req_addr  <= '0;
         line      <= '0;
         resp_line <= '0;
         err_flag  <= 1'b0;
      end else begin
         if (accept) begin
            beat     <= '0;
            err_flag <= 1'b0;
            req_addr <= {bus.miss_req_addr[31:OFF_W], {OFF_W{1'b0}}};
         end
         if (beat_done) begin
            line     <= line_merged;
            err_flag <= err_flag | bus.mem_resp_err;
            if (last_beat) begin
               resp_line <= line_merged;
            end else begin
               beat     <= beat + 1'b1;
               req_addr <= req_addr + 32'(WORD_BYTES);
            end
         end
      end
   end
endmodule

// File: tb/tb_mcu_icache_refill.sv
// Randomized self-checking bench for mcu_icache_refill against a line-level memory model.
`timescale 1ns/1ps
module tb_mcu_icache_refill;
   localparam int LINE_BYTES = 32;
   localparam int BEATS      = LINE_BYTES / 4;
   localparam int LW         = LINE_BYTES * 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mcu_icache_refill_if #(.LINE_BYTES(LINE_BYTES)) bus ();

   mcu_icache_refill #(.LINE_BYTES(LINE_BYTES), .WORD_BYTES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp   = 0;
   int n_bad   = 0;
   int n_pulse = 0;
   int lat     = 0;
   logic [LW-1:0] last_line;

   always @(posedge clk) if (bus.miss_resp_valid) n_pulse <= n_pulse + 1;

   task automatic chk_val(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      lat++;
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] salt);
      return a ^ salt;
   endfunction

   function automatic logic [LW-1:0] exp_line(input logic [31:0] addr, input logic [31:0] salt);
      logic [LW-1:0] l;
      logic [31:0]   base;
      base = addr & ~32'(LINE_BYTES - 1);
      l = '0;
      for (int k = 0; k < BEATS; k++) l[k*32 +: 32] = mem_word(base + 32'(4*k), salt);
      return l;
   endfunction

   // stall/dly < 0 selects random per-beat timing plus junk traffic that must be ignored.
   task automatic refill(input logic [31:0] addr, input logic [31:0] salt, input int stall,
                         input int dly, input logic [BEATS-1:0] errm, input int abort_at,
                         input bit chk_lat);
      logic [31:0]   base;
      logic [LW-1:0] eline;
      int            st, dl, guard, p0;
      base  = addr & ~32'(LINE_BYTES - 1);
      eline = exp_line(addr, salt);
      p0    = n_pulse;
      chk_val("resp_hold", bus.miss_resp_data, last_line);
      chk_val("idle_rdy", bus.miss_req_ready, 1);
      bus.miss_req_valid = 1'b1;
      bus.miss_req_addr  = addr;
      lat = 0;
      tick();
      bus.miss_req_valid = 1'b0;
      for (int k = 0; k < BEATS; k++) begin
         st = (stall < 0) ? $urandom_range(0, 3) : stall;
         dl = (dly < 0) ? $urandom_range(1, 4) : dly;
         guard = 0;
         while (!bus.mem_req_valid && guard < 20) begin
            tick();
            guard++;
         end
         chk_val("req_vld", bus.mem_req_valid, 1);
         chk_val("req_addr", bus.mem_req_addr, base + 32'(4*k));
         for (int s = 0; s < st; s++) begin
            bus.mem_req_ready  = 1'b0;
            bus.miss_req_valid = 1'b1;
            bus.miss_req_addr  = $urandom;
            if (stall < 0) begin
               bus.mem_resp_valid = 1'($urandom_range(0, 1));
               bus.mem_resp_data  = $urandom;
               bus.mem_resp_err   = 1'($urandom_range(0, 1));
            end
            tick();
            bus.miss_req_valid = 1'b0;
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_err   = 1'b0;
            chk_val("stall_vld", bus.mem_req_valid, 1);
            chk_val("stall_addr", bus.mem_req_addr, base + 32'(4*k));
            chk_val("busy_rdy", bus.miss_req_ready, 0);
         end
         bus.mem_req_ready = 1'b1;
         tick();
         bus.mem_req_ready = 1'b0;
         if (k == abort_at) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            last_line = '0;
            chk_val("abort_rdy", bus.miss_req_ready, 1);
            chk_val("abort_mvld", bus.mem_req_valid, 0);
            chk_val("abort_data", bus.miss_resp_data, '0);
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = mem_word(base + 32'(4*k), salt);
            tick();
            bus.mem_resp_valid = 1'b0;
            chk_val("late_rdy", bus.miss_req_ready, 1);
            chk_val("late_mvld", bus.mem_req_valid, 0);
            chk_val("late_data", bus.miss_resp_data, '0);
            chk_val("abort_nopulse", n_pulse, p0);
            return;
         end
         for (int d = 1; d < dl; d++) begin
            bus.mem_req_ready = (stall < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            chk_val("wait_vld", bus.mem_req_valid, 0);
         end
         bus.mem_req_ready  = 1'b0;
         bus.mem_resp_valid = 1'b1;
         bus.mem_resp_data  = mem_word(base + 32'(4*k), salt);
         bus.mem_resp_err   = errm[k];
         tick();
         bus.mem_resp_valid = 1'b0;
         bus.mem_resp_err   = 1'b0;
      end
      chk_val("resp_vld", bus.miss_resp_valid, 1);
      chk_val("resp_data", bus.miss_resp_data, eline);
      chk_val("resp_err", bus.miss_resp_err, |errm);
      chk_val("done_rdy", bus.miss_req_ready, 0);
      if (chk_lat) chk_val("latency", lat, 2*BEATS + 1);
      tick();
      chk_val("resp_pulse", bus.miss_resp_valid, 0);
      chk_val("pulse_cnt", n_pulse, p0 + 1);
      chk_val("next_rdy", bus.miss_req_ready, 1);
      last_line = eline;
   endtask

   initial begin
      logic [BEATS-1:0] em;
      rst = 1'b1;
      bus.miss_req_valid = 1'b0;
      bus.miss_req_addr  = '0;
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = '0;
      bus.mem_resp_err   = 1'b0;
      last_line = '0;
      tick();
      tick();
      rst = 1'b0;
      chk_val("rst_rdy", bus.miss_req_ready, 1);
      chk_val("rst_mvld", bus.mem_req_valid, 0);
      chk_val("rst_maddr", bus.mem_req_addr, 0);
      chk_val("rst_rvld", bus.miss_resp_valid, 0);
      chk_val("rst_rdata", bus.miss_resp_data, '0);
      chk_val("rst_rerr", bus.miss_resp_err, 0);

      refill(32'h0000_1234, 32'h0, 0, 1, '0, -1, 1);
      refill(32'h0000_1234, 32'h0, 3, 5, '0, -1, 0);
      refill($urandom, $urandom, 0, 1, BEATS'(8), -1, 1);
      refill($urandom, $urandom, 0, 1, '0, -1, 1);

      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 32'hDEAD_BEEF;
      bus.mem_resp_err   = 1'b1;
      tick();
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_err   = 1'b0;
      chk_val("spur_rdy", bus.miss_req_ready, 1);
      chk_val("spur_mvld", bus.mem_req_valid, 0);
      chk_val("spur_data", bus.miss_resp_data, last_line);

      refill(32'h0000_4444, 32'h1357_9BDF, 0, 2, '0, 4, 0);
      refill(32'h8000_0000, $urandom, 1, 2, '0, -1, 0);
      refill(32'hFFFF_FFFC, 32'h0, 0, 1, '0, -1, 1);

      rst = 1'b1;
      bus.miss_req_valid = 1'b1;
      bus.miss_req_addr  = 32'h0000_2000;
      tick();
      rst = 1'b0;
      bus.miss_req_valid = 1'b0;
      last_line = '0;
      chk_val("rstreq_mvld", bus.mem_req_valid, 0);
      tick();
      chk_val("rstreq_mvld2", bus.mem_req_valid, 0);
      chk_val("rstreq_rdy", bus.miss_req_ready, 1);

      for (int i = 0; i < 20; i++) begin
         em = '0;
         if ($urandom_range(0, 3) == 0) em[$urandom_range(0, BEATS-1)] = 1'b1;
         refill($urandom, $urandom, -1, -1, em, -1, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
